mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of mips_cpu_bus between two masters: the instruction-fetch port (I, read-only) and the load/store data port (D).
- Grants one master per transaction, with round-robin priority.
- Forwards the granted master's request to memory and returns completion and read data to it.
- Includes a watchdog that aborts transactions stalled by waitrequest and flags the error.

Parameters:
- TIMEOUT_CYCLES, 256: consecutive stalled cycles before a transaction is aborted; 0 disables the watchdog.
- ABORT_DATA, 32'hDEADBEEF: readdata returned to the owner on a timeout abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- i_address  input  32  instruction fetch byte address.
- i_read  input  1  fetch request.
- i_waitrequest  output  1  low only in the cycle the fetch completes.
- i_readdata  output  32  fetch data, valid when i_waitrequest is low.
- d_address  input  32  data byte address.
- d_read  input  1  load request.
- d_write  input  1  store request.
- d_byteenable  input  4  store/load byte lanes.
- d_writedata  input  32  store data.
- d_waitrequest  output  1  low only in the cycle the data access completes.
- d_readdata  output  32  load data, valid when d_waitrequest is low.
- m_address, m_read, m_write, m_byteenable, m_writedata  output  32/1/1/4/32  memory bus request.
- m_waitrequest  input  1  memory stall.
- m_readdata  input  32  memory read data, valid in the cycle the read completes.
- grant_d  output  1  1 while D owns the bus.
- busy  output  1  1 while any master owns the bus.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- State machine with states IDLE, BUSY_I, BUSY_D. The state, last_owner, the stall counter and timeout_err are registers. All outputs are combinational from these registers and the inputs.
- Reset (asynchronous, reset==0):
  - state=IDLE, last_owner=D, counter=0, timeout_err=0.
  - Outputs immediately become: m_read=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, i_waitrequest=1, d_waitrequest=1, grant_d=0, busy=0.
  - A transaction in flight is dropped with no completion returned.
- IDLE:
  - m_* outputs are all 0 and both waitrequests are 1.
  - reqI = i_read. reqD = d_read | d_write.
  - If only one master requests, it wins.
  - If both request, the master that is not last_owner wins. Because last_owner resets to D, I wins the first tie.
  - The winner becomes the next state, BUSY_I or BUSY_D. Arbitration costs one cycle.
- BUSY_x:
  - m_address, m_read, m_write, m_byteenable and m_writedata mirror the owner's inputs.
  - For I, m_write=0 and m_byteenable=4'b1111.
  - For D, if d_read and d_write are both high, the access is treated as a write and m_read is forced to 0.
  - The non-owner's waitrequest is held at 1.
- Completion: a cycle in BUSY_x where m_waitrequest=0 and the forwarded read or write is high.
  - The owner's waitrequest is 0 in that cycle.
  - The owner's readdata equals m_readdata in that cycle.
  - Next state is IDLE, last_owner is set to the owner, and the counter is cleared.
  - Minimum transaction is 2 cycles: 1 arbitration cycle plus 1 bus cycle.
- Owner withdraws its request in BUSY (protocol violation): go to IDLE with no completion, last_owner unchanged.
- i_readdata and d_readdata equal m_readdata whenever not aborting.
- Watchdog (TIMEOUT_CYCLES>0):
  - The counter increments on each BUSY cycle with m_waitrequest=1 and saturates.
  - When the counter reaches TIMEOUT_CYCLES, the next BUSY cycle is an abort cycle:
    - m_read and m_write are forced to 0.
    - The owner's waitrequest is 0 and its readdata is ABORT_DATA.
    - timeout_err is set to 1.
    - Next state is IDLE and last_owner is updated as on a normal completion.
  - timeout_err is cleared only by reset.
- busy = (state != IDLE). grant_d = (state == BUSY_D).
- Requesters must hold their request stable until they see waitrequest low. The arbiter does not latch request fields; it forwards them live.

Test Plan:
- Single fetch: i_read=1, i_address=32'hBFC00000, memory has no stalls and returns 32'h8C010064 → m_read=1 in cycle 2, i_waitrequest=0 and i_readdata=32'h8C010064 in that cycle, busy=0 in cycle 3.
- Tie after reset: i_read and d_write asserted in the same cycle, d_address=200, d_writedata=123 → I served first, then D. m_write=1 with m_address=200, m_writedata=123 and m_byteenable=d_byteenable. d_waitrequest=1 throughout I's transaction.
- Round-robin: both masters request continuously for 4 transactions → grant order I, D, I, D. grant_d toggles accordingly.
- Stall: m_waitrequest=1 for 3 bus cycles on a D load from address 101 → d_waitrequest=1 for those cycles, then 0 with d_readdata=404. timeout_err=0.
- Timeout with TIMEOUT_CYCLES=4: m_waitrequest held at 1 → abort cycle after 4 stalled cycles with m_read=0, owner readdata=32'hDEADBEEF and waitrequest=0. timeout_err=1 and stays 1 through subsequent good transactions.
- Reset mid-operation: reset driven to 0 in the second stalled cycle of a store → m_write=0 with no clock edge needed and state=IDLE. After reset returns to 1, a new fetch is granted normally.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter sharing one Avalon-style memory bus
// between the instruction-fetch master (I, read-only) and the load/store
// master (D). Requests are forwarded live, not latched. A watchdog aborts
// transactions that stay stalled too long and raises a sticky error flag.
module mips_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   // instruction fetch master
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   // load/store master
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [3:0]  d_byteenable,
   input  logic [31:0] d_writedata,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   // memory bus
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [3:0]  m_byteenable,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   // status
   output logic        grant_d,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

   // Counter only needs to reach TIMEOUT_CYCLES, where it saturates.
   localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
   localparam bit         WDOG_EN = (TIMEOUT_CYCLES != 0);

   state_e        state_q, state_d;
   logic          last_d_q, last_d_d;   // 1: D owned the last transaction
   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q, terr_d;

   logic own_i, own_d;
   logic own_rd, own_wr, own_req;
   logic abort, done, finish;
   logic req_i, req_d;

   assign own_i = (state_q == BUSY_I);
   assign own_d = (state_q == BUSY_D);

   // A simultaneous D read+write is treated as a write.
   assign own_rd  = (own_i & i_read) | (own_d & d_read & ~d_write);
   assign own_wr  = own_d & d_write;
   assign own_req = own_rd | own_wr;

   // Abort cycle: the stall counter has hit its limit while the owner still requests.
   assign abort  = WDOG_EN && own_req && (cnt_q == CNT_MAX);
   assign done   = own_req & ~m_waitrequest & ~abort;
   assign finish = done | abort;

   assign req_i = i_read;
   assign req_d = d_read | d_write;

   // Bus request forwarding from the current owner; all zero when idle.
   always_comb begin
      m_address    = 32'h0;
      m_byteenable = 4'h0;
      m_writedata  = 32'h0;
      if (own_i) begin
         m_address    = i_address;
         m_byteenable = 4'b1111;
      end else if (own_d) begin
         m_address    = d_address;
         m_byteenable = d_byteenable;
         m_writedata  = d_writedata;
      end
   end

   assign m_read  = own_rd & ~abort;
   assign m_write = own_wr & ~abort;

   assign i_waitrequest = ~(own_i & finish);
   assign d_waitrequest = ~(own_d & finish);
   assign i_readdata    = (own_i & abort) ? ABORT_DATA : m_readdata;
   assign d_readdata    = (own_d & abort) ? ABORT_DATA : m_readdata;

   assign busy        = (state_q != IDLE);
   assign grant_d     = own_d;
   assign timeout_err = terr_q;

   // Next-state: arbitration in IDLE, completion/abort/withdraw/stall in BUSY.
   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      cnt_d    = cnt_q;
      terr_d   = terr_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (req_i && (!req_d || last_d_q))
            state_d = BUSY_I;
         else if (req_d)
            state_d = BUSY_D;
      end else if (!own_req) begin
         // owner dropped its request: no completion, history unchanged
         state_d = IDLE;
         cnt_d   = '0;
      end else if (finish) begin
         state_d  = IDLE;
         last_d_d = own_d;
         cnt_d    = '0;
         terr_d   = terr_q | abort;
      end else if (WDOG_EN && m_waitrequest && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         last_d_q <= 1'b1;
         cnt_q    <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         cnt_q    <= cnt_d;
         terr_q   <= terr_d;
      end
   end

endmodule
